// File: rtl/rr_mux4x1.sv
// rr_mux4x1: 4:1 round-robin valid/ready stream mux with a registered, source-tagged output.
// Define RR_MUX_PKT_LOCK_EN to keep the grant on one channel until that channel's in_last beat.
module rr_mux4x1 #(
    parameter int unsigned DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            in_valid,
    input  logic [4*DATA_W-1:0]   in_data,
    input  logic [3:0]            in_last,
    output logic [3:0]            in_ready,
    output logic                  out_valid,
    output logic [DATA_W-1:0]     out_data,
    output logic [1:0]            out_sel,
    output logic                  out_last,
    input  logic                  out_ready
);
    localparam int unsigned N_CH = 4;
    localparam int unsigned CH_W = 2;

    logic [CH_W-1:0] rr_ptr;
    logic            grant_vld;
    logic [CH_W-1:0] grant_ch;
    logic            load_en;
    logic            xfer;
    logic            ptr_adv;

    assign load_en = ~out_valid | out_ready;
    assign xfer    = grant_vld & load_en & ~rst;

`ifdef RR_MUX_PKT_LOCK_EN
    typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CH_W-1:0] lock_ch;
    logic [CH_W-1:0] lock_ch_nxt;
    logic            locked;

    // Packet-lock state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            lock_ch <= '0;
        end else begin
            state   <= state_nxt;
            lock_ch <= lock_ch_nxt;
        end
    end

    // A non-last beat opens (or continues) a packet; a last beat closes it
    always_comb begin
        state_nxt   = state;
        lock_ch_nxt = lock_ch;
        if (xfer) begin
            if (in_last[grant_ch]) begin
                state_nxt = ST_IDLE;
            end else begin
                state_nxt   = ST_LOCKED;
                lock_ch_nxt = grant_ch;
            end
        end
    end

    // Pointer only moves past a channel once its packet has ended
    always_comb begin
        locked  = (state == ST_LOCKED);
        ptr_adv = xfer & in_last[grant_ch];
    end
`else
    assign ptr_adv = xfer;
`endif

    // Round-robin search; walking offsets downward lets the nearest valid channel win
    always_comb begin
        grant_vld = 1'b0;
        grant_ch  = '0;
        for (int k = int'(N_CH) - 1; k >= 0; k--) begin
            if (in_valid[rr_ptr + CH_W'(k)]) begin
                grant_vld = 1'b1;
                grant_ch  = rr_ptr + CH_W'(k);
            end
        end
`ifdef RR_MUX_PKT_LOCK_EN
        if (locked) begin
            grant_vld = in_valid[lock_ch];
            grant_ch  = lock_ch;
        end
`endif
    end

    always_comb begin
        in_ready = '0;
        if (xfer) in_ready[grant_ch] = 1'b1;
    end

    // Output register and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            out_last  <= 1'b0;
            rr_ptr    <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= in_data[grant_ch*DATA_W +: DATA_W];
            out_sel   <= grant_ch;
            out_last  <= in_last[grant_ch];
            if (ptr_adv) rr_ptr <= grant_ch + CH_W'(1);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_mux4x1.sv
// tb_rr_mux4x1: directed and random stimulus against a queue-free behavioural model of the
// round-robin merge (honours RR_MUX_PKT_LOCK_EN when defined).
module tb_rr_mux4x1;
    localparam int unsigned DATA_W = 8;

    logic                  clk;
    logic                  rst;
    logic [3:0]            in_valid;
    logic [4*DATA_W-1:0]   in_data;
    logic [3:0]            in_last;
    logic [3:0]            in_ready;
    logic                  out_valid;
    logic [DATA_W-1:0]     out_data;
    logic [1:0]            out_sel;
    logic                  out_last;
    logic                  out_ready;

    int n_cmp = 0;
    int n_err = 0;

    // behavioural model state
    int          m_ptr;
    int          m_lch;
    int          m_sel;
    int          m_grant;
    bit          m_lock;
    bit          m_valid;
    bit          m_last;
    logic [7:0]  m_data;

    rr_mux4x1 #(.DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr   = 0;
        m_lch   = 0;
        m_sel   = 0;
        m_lock  = 1'b0;
        m_valid = 1'b0;
        m_last  = 1'b0;
        m_data  = 8'h00;
    endtask

    // Channel the rules pick for the current inputs, -1 when none
    function automatic int pick();
        if (m_lock) return in_valid[m_lch] ? m_lch : -1;
        for (int off = 0; off < 4; off++)
            if (in_valid[(m_ptr + off) % 4]) return (m_ptr + off) % 4;
        return -1;
    endfunction

    // Called at posedge+1 with inputs applied; checks at negedge, advances model on the edge
    task automatic step();
        int         g;
        bit         take;
        logic [3:0] exp_rdy;
        #4;
        g       = pick();
        take    = !rst && g >= 0 && (!m_valid || out_ready);
        exp_rdy = take ? 4'(1 << g) : 4'b0000;
        check("in_ready",  32'(in_ready),  32'(exp_rdy));
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("out_data",  32'(out_data),  32'(m_data));
        check("out_sel",   32'(out_sel),   32'(m_sel));
        check("out_last",  32'(out_last),  32'(m_last));
        @(posedge clk);
        m_grant = take ? g : -1;
        if (rst) begin
            model_reset();
        end else if (take) begin
            m_valid = 1'b1;
            m_data  = in_data[g*8 +: 8];
            m_sel   = g;
            m_last  = in_last[g];
`ifdef RR_MUX_PKT_LOCK_EN
            if (in_last[g]) begin
                m_lock = 1'b0;
                m_ptr  = (g + 1) % 4;
            end else begin
                m_lock = 1'b1;
                m_lch  = g;
            end
`else
            m_ptr = (g + 1) % 4;
`endif
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    initial begin
        int ch1_sent;
        int exp_t6 [5];
        int n_t6;

        rst       = 1'b1;
        in_valid  = 4'hF;
        in_data   = 32'h1312_1110;
        in_last   = 4'hF;
        out_ready = 1'b1;
        model_reset();
        m_grant = -1;

        // T1: reset held two edges with every channel valid
        @(posedge clk);
        #1;
        step();
        check("t1_out_valid", 32'(out_valid), 32'd0);
        check("t1_out_sel",   32'(out_sel),   32'd0);
        rst = 1'b0;

        // T3: all channels valid, fair rotation from channel 0
        for (int i = 0; i < 8; i++) begin
            step();
            check("t3_sel",  32'(out_sel),  32'(i % 4));
            check("t3_data", 32'(out_data), 32'(8'h10 + 8'(i % 4)));
        end

        // T4: backpressure holds the last beat and blocks all inputs
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t4_hold_sel",  32'(out_sel),  32'd3);
            check("t4_hold_data", 32'(out_data), 32'h13);
        end
        out_ready = 1'b1;
        step();
        check("t4_release_sel", 32'(out_sel), 32'd0);
        in_valid = 4'h0;
        step();

        // T2: lone channel 2
        in_valid = 4'b0100;
        in_data  = 32'h00A5_0000;
        step();
        check("t2_valid", 32'(out_valid), 32'd1);
        check("t2_data",  32'(out_data),  32'hA5);
        check("t2_sel",   32'(out_sel),   32'd2);
        in_valid = 4'h0;
        step();

        // T5: pointer wraps 3 -> 0
        in_valid = 4'b1000;
        in_data  = 32'h3300_0000;
        step();
        check("t5_first_sel", 32'(out_sel), 32'd3);
        in_valid = 4'b1001;
        in_data  = 32'h3300_0030;
        step();
        check("t5_wrap_sel", 32'(out_sel), 32'd0);
        in_valid = 4'h0;
        step();

        // T6: ch1 three-beat packet contending with ch0 and ch2
`ifdef RR_MUX_PKT_LOCK_EN
        exp_t6 = '{1, 1, 1, 2, 0};
        n_t6   = 5;
`else
        exp_t6 = '{1, 2, 0, 1, 0};
        n_t6   = 4;
`endif
        ch1_sent = 0;
        for (int i = 0; i < n_t6; i++) begin
            in_valid = (ch1_sent < 3) ? 4'b0111 : 4'b0101;
            in_last  = {1'b1, 1'b1, (ch1_sent == 2), 1'b1};
            in_data  = {8'h00, 8'h40, 8'(8'h30 + 8'(ch1_sent)), 8'h20};
            step();
            if (m_grant == 1) ch1_sent++;
            check("t6_sel", 32'(out_sel), 32'(exp_t6[i]));
        end
        in_valid = 4'h0;
        in_last  = 4'hF;
        step();

        // Random traffic, backpressure and occasional reset against the model
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 63) == 0);
            in_valid  = 4'($urandom);
            in_data   = $urandom;
            in_last   = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
